// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the instruction-fetch
//            requester and the data load/store requester. One access per
//            cycle. Data has priority, but fetch is forced through after
//            STARVE_MAX back-to-back data grants. Each one-cycle read response
//            is returned to the requester that issued the read. Out-of-range
//            addresses are granted but never reach memory, and they set a
//            sticky error flag.
// Ports    : clk, reset (async, active-low)
//            imem_*     : fetch request / ready / response
//            dmem_*     : data request / ready / response
//            mem_*      : memory read/write strobes, addresses and data
//            addr_error : sticky out-of-range flag
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEMSIZE    = 128*1024,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic        imem_valid,
  output logic [31:0] imem_rdata,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic        dmem_valid,
  output logic [31:0] dmem_rdata,
  output logic        mem_read_ready,
  output logic        mem_write_ready,
  output logic [29:0] mem_read_address,
  output logic [29:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte,
  input  logic [31:0] mem_read_data,
  output logic        addr_error
);

  localparam int         c_AW         = $clog2(MEMSIZE);
  localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_t;

  owner_t      r_owner;
  logic        r_resp_zero;   // pending read was out of range: deliver 0
  logic [2:0]  r_starve_cnt;
  logic        r_addr_error;

  logic        w_grant_i;
  logic        w_grant_d;
  logic [31:0] w_req_addr;
  logic        w_in_range;
  logic        w_is_read;
  logic        w_is_write;
  logic        w_unused_addr_bits;

  // Word addressing: the byte-offset bits carry no information here.
  assign w_unused_addr_bits = ^{imem_addr[1:0], dmem_addr[1:0]};

  always_comb begin
    // Holding reset low suppresses grants so every output reads 0 in reset.
    w_grant_i  = reset & imem_req &
                 (~dmem_req | (r_starve_cnt == c_STARVE_MAX));
    w_grant_d  = reset & dmem_req & ~w_grant_i;
    w_req_addr = w_grant_d ? dmem_addr : imem_addr;
    w_in_range = (w_req_addr[31:c_AW] == '0);
    w_is_read  = w_grant_i | (w_grant_d & ~dmem_we);
    w_is_write = w_grant_d & dmem_we;

    mem_read_ready    = 1'b0;
    mem_write_ready   = 1'b0;
    mem_read_address  = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_write_byte    = '0;
    if (w_in_range && w_is_read) begin
      mem_read_ready   = 1'b1;
      mem_read_address = w_req_addr[31:2];
    end
    if (w_in_range && w_is_write) begin
      mem_write_ready   = 1'b1;
      mem_write_address = w_req_addr[31:2];
      mem_write_data    = dmem_wdata;
      mem_write_byte    = dmem_wstrb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWN_NONE;
      r_resp_zero  <= 1'b0;
      r_starve_cnt <= 3'd0;
      r_addr_error <= 1'b0;
    end else begin
      if (w_grant_i)
        r_owner <= OWN_IMEM;
      else if (w_grant_d && !dmem_we)
        r_owner <= OWN_DMEM;
      else
        r_owner <= OWN_NONE;

      r_resp_zero <= w_is_read & ~w_in_range;

      // Counts data grants that pushed a waiting fetch aside.
      if (imem_req && w_grant_d) begin
        if (r_starve_cnt != c_STARVE_MAX)
          r_starve_cnt <= r_starve_cnt + 3'd1;
      end else begin
        r_starve_cnt <= 3'd0;
      end

      if ((w_grant_i || w_grant_d) && !w_in_range)
        r_addr_error <= 1'b1;
    end
  end

  assign imem_ready = w_grant_i;
  assign dmem_ready = w_grant_d;
  assign imem_valid = (r_owner == OWN_IMEM);
  assign dmem_valid = (r_owner == OWN_DMEM);
  assign imem_rdata = (imem_valid && !r_resp_zero) ? mem_read_data : 32'd0;
  assign dmem_rdata = (dmem_valid && !r_resp_zero) ? mem_read_data : 32'd0;
  assign addr_error = r_addr_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter, with a small
//            behavioural single-ported memory attached.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_valid;
  logic [31:0] dmem_rdata;
  logic        mem_read_ready, mem_write_ready;
  logic [29:0] mem_read_address, mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_byte;
  logic [31:0] mem_read_data;
  logic        addr_error;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEMSIZE(128*1024), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_valid(dmem_valid), .dmem_rdata(dmem_rdata),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_byte(mem_write_byte),
    .mem_read_data(mem_read_data), .addr_error(addr_error)
  );

  // Behavioural memory: word i preloaded with 0x1000_0000 + i, 1-cycle read.
  logic [31:0] mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    mem_read_data = 32'd0;
  end
  always @(posedge clk) begin
    if (mem_read_ready) mem_read_data <= mem[mem_read_address[9:0]];
    if (mem_write_ready)
      for (int b = 0; b < 4; b++)
        if (mem_write_byte[b])
          mem[mem_write_address[9:0]][8*b +: 8] <= mem_write_data[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge; inputs are driven there, outputs checked #1 later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_we = 0;
    dmem_addr = 0; dmem_wdata = 0; dmem_wstrb = 0;
    step(); step(); #1;
    chk("rst_imem_valid", 32'(imem_valid), 0);
    chk("rst_dmem_valid", 32'(dmem_valid), 0);
    chk("rst_addr_error", 32'(addr_error), 0);
    chk("rst_rd_ready",   32'(mem_read_ready), 0);
    reset = 1'b1;

    // ---- fetch only: 0x0, 0x4, 0x8 back to back
    step(); imem_req = 1; imem_addr = 32'h0; #1;
    chk("f0_ready", 32'(imem_ready), 1);
    chk("f0_rd_ready", 32'(mem_read_ready), 1);
    chk("f0_rd_addr", 32'(mem_read_address), 0);
    step(); imem_addr = 32'h4; #1;
    chk("f1_ready", 32'(imem_ready), 1);
    chk("f0_valid", 32'(imem_valid), 1);
    chk("f0_rdata", imem_rdata, 32'h1000_0000);
    chk("f0_dvalid", 32'(dmem_valid), 0);
    step(); imem_addr = 32'h8; #1;
    chk("f2_ready", 32'(imem_ready), 1);
    chk("f1_rdata", imem_rdata, 32'h1000_0001);
    step(); imem_req = 0; #1;
    chk("f2_valid", 32'(imem_valid), 1);
    chk("f2_rdata", imem_rdata, 32'h1000_0002);
    chk("f2_dvalid", 32'(dmem_valid), 0);
    step(); #1;
    chk("f_idle_valid", 32'(imem_valid), 0);

    // ---- data write then read at 0x100
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h100;
    dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF; #1;
    chk("w_ready", 32'(dmem_ready), 1);
    chk("w_wr_ready", 32'(mem_write_ready), 1);
    chk("w_wr_addr", 32'(mem_write_address), 32'h40);
    chk("w_rd_ready", 32'(mem_read_ready), 0);
    step(); dmem_we = 0; #1;
    chk("w_no_valid", 32'(dmem_valid), 0);
    chk("r_ready", 32'(dmem_ready), 1);
    step(); dmem_req = 0; #1;
    chk("r_valid", 32'(dmem_valid), 1);
    chk("r_rdata", dmem_rdata, 32'hDEAD_BEEF);
    chk("r_ivalid", 32'(imem_valid), 0);

    // ---- byte-strobe write 0xAA to byte 0, read back
    step(); dmem_req = 1; dmem_we = 1; dmem_wdata = 32'h0000_00AA; dmem_wstrb = 4'h1; #1;
    chk("bw_byte", 32'(mem_write_byte), 32'h1);
    step(); dmem_we = 0; #1;
    step(); dmem_req = 0; #1;
    chk("bw_rdata", dmem_rdata, 32'hDEAD_BEAA);

    // ---- contention: D D D D I repeating
    step(); imem_req = 1; imem_addr = 32'hC; dmem_req = 1; dmem_we = 0; dmem_addr = 32'h100; #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("st_iready_%0d", k), 32'(imem_ready), (k % 5 == 4) ? 1 : 0);
      chk($sformatf("st_dready_%0d", k), 32'(dmem_ready), (k % 5 == 4) ? 0 : 1);
      step(); #1;
      chk($sformatf("st_ivalid_%0d", k), 32'(imem_valid), (k % 5 == 4) ? 1 : 0);
    end
    imem_req = 0; dmem_req = 0;
    step(); #1;
    chk("st_idle", 32'(dmem_valid), 0);

    // ---- out-of-range data read
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h0002_0000; #1;
    chk("oor_ready", 32'(dmem_ready), 1);
    chk("oor_rd_ready", 32'(mem_read_ready), 0);
    chk("oor_err_early", 32'(addr_error), 0);
    step(); dmem_req = 0; imem_req = 1; imem_addr = 32'h0; #1;
    chk("oor_valid", 32'(dmem_valid), 1);
    chk("oor_rdata", dmem_rdata, 0);
    chk("oor_err", 32'(addr_error), 1);
    step(); imem_req = 0; #1;
    chk("oor_after_rdata", imem_rdata, 32'h1000_0000);
    chk("oor_err_held", 32'(addr_error), 1);

    // ---- reset in the middle of a fetch
    step(); imem_req = 1; imem_addr = 32'h4; #1;
    chk("rm_ready", 32'(imem_ready), 1);
    #2 reset = 1'b0; imem_req = 0;
    step(); #1;
    chk("rm_ivalid", 32'(imem_valid), 0);
    chk("rm_irdata", imem_rdata, 0);
    chk("rm_err", 32'(addr_error), 0);
    reset = 1'b1;
    step(); #1;
    chk("rm_post_valid", 32'(imem_valid), 0);
    imem_req = 1; imem_addr = 32'h8; #1;
    chk("rm_fresh_ready", 32'(imem_ready), 1);
    step(); imem_req = 0; #1;
    chk("rm_fresh_rdata", imem_rdata, 32'h1000_0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
